xor_mux_pipe: RTL and testbench
===============================

// Module: xor_mux_pipe
// PURPOSE
//  Parametrised, pipelined bitwise XOR unit with valid/ready handshake. Each bit is
//  built only from 2:1 mux cells, constants 0/1 and wires. Output is registered.
//  Sits between a producer and a consumer stream. Also returns the parity of the
//  result and a count of completed output transfers.
// PARAMETERS
//  WIDTH    8  operand/result width in bits, >= 1
//  DEPTH    2  number of register stages (latency), 1..xor_mux_pipe_pkg::MAX_DEPTH
//  COUNT_W  8  width of the transfer counter, >= 1
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous reset, active-low
//  up_valid    in   1        producer has operands
//  up_ready    out  1        block accepts operands this cycle
//  a           in   WIDTH    operand A
//  b           in   WIDTH    operand B
//  down_valid  out  1        result available
//  down_ready  in   1        consumer takes result this cycle
//  y           out  WIDTH    a ^ b (XNOR when inverted, see CONFIGURATION)
//  parity      out  1        reduction XOR of y
//  count       out  COUNT_W  number of completed down transfers, modulo 2**COUNT_W
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valids=0, data regs=0, down_valid=0, y=0,
//    parity=0, count=0. Any data in flight is dropped. up_ready=1 once rst_n=1.
//  - Up transfer when up_valid&&up_ready. Down transfer when down_valid&&down_ready.
//  - y=a^b is computed combinationally at capture by the mux cells. parity=^y is
//    computed in the same cycle and travels with y.
//  - Stage k loads when !valid[k] || ready_in[k+1]. For the last stage,
//    ready_in = down_ready.
//  - up_ready = !valid[0] || ready_in[1]. This is a combinational backpressure
//    chain with no skid buffer.
//  - Latency is DEPTH cycles from the up transfer to down_valid.
//  - Throughput is 1 per cycle while down_ready=1. No bubbles are inserted.
//  - Stall: while down_valid && !down_ready, y, parity and down_valid stay stable.
//    Upstream stages fill. up_ready falls only when all DEPTH stages are valid.
//  - Full pipe with down_ready=1 and up_valid=1: a shift-in and a shift-out happen
//    in the same cycle. No loss, no duplication.
//  - count increments by 1 per down transfer and wraps from 2**COUNT_W-1 to 0.
//  - DEPTH out of range is an elaboration error ($error in a generate check).
//  - X on a or b while up_valid=0 must not propagate to the outputs.
// CONFIGURATION
//  XOR_MUX_PIPE_INVERT_EN defined:
//    - adds input port "invert" (1 bit), sampled together with a and b on an up
//      transfer.
//    - invert=1 makes y = ~(a^b), built from the same mux cells with swapped
//      constants; parity=^y.
//    - invert is registered per transfer, so mixed streams are exact.
//  XOR_MUX_PIPE_INVERT_EN undefined:
//    - no invert port; y = a^b always.
// STRUCTURE
//  - Package xor_mux_pipe_pkg:
//      localparam MAX_DEPTH = 4;
//      typedef struct packed stage_t: { valid, parity, inv } shared by all stages.
//      The WIDTH-wide data field is kept in a separate array.
//  - Sub-module xor_bits_using_mux:
//      parameter WIDTH; combinational; two mux instances per bit; constants 0/1
//      and wires only, no ^ operator.
//  - The top module holds the DEPTH-stage register array, the ready chain and the
//    counter.
// TESTING
//  1. Reset, WIDTH=8, DEPTH=2: hold rst_n=0 -> down_valid=0, y=0, count=0,
//     up_ready=1 after release.
//  2. Single transfer: a=8'hA5, b=8'h0F, down_ready=1 -> down_valid on cycle 2,
//     y=8'hAA, parity=0, count=1.
//  3. Back-to-back: 256 transfers, exhaustive over a[3:0] x b[3:0] (rest 0),
//     down_ready=1 -> one result per cycle, in order, y==a^b every time.
//  4. Backpressure: stream 4 items, down_ready=0 for 5 cycles ->
//     - y stays stable while stalled;
//     - up_ready=0 after 2 accepted items;
//     - release delivers all 4 items in order.
//  5. Wrap: COUNT_W=4, 17 transfers -> count reads 0 after 16 transfers, then 1
//     after the 17th.
//  6. Reset mid-stream: assert rst_n=0 with 2 items in flight -> down_valid=0 at
//     once, no stale item after release.
//     With XOR_MUX_PIPE_INVERT_EN: a=8'hFF, b=8'h00, invert=1 -> y=8'h00,
//     parity=0.

Source files
------------

// File: rtl/xor_mux_pipe_pkg.sv
// Shared types, limits and the mux cell used by the xor_mux_pipe datapath.
// Optional feature macro: XOR_MUX_PIPE_INVERT_EN (see xor_mux_pipe.sv).
package xor_mux_pipe_pkg;

   localparam int MAX_DEPTH = 4;

   typedef struct packed {
      logic valid;
      logic parity;
      logic inv;
   } stage_t;

   // Single 2:1 mux cell; every result bit is composed only of these.
   function automatic logic mux2(input logic sel, input logic d0, input logic d1);
      return sel ? d1 : d0;
   endfunction

endpackage

// File: rtl/xor_bits_using_mux.sv
// Bitwise XOR (or XNOR with XOR_MUX_PIPE_INVERT_EN and inv=1) built from mux cells.
// Per bit: y = a ? ~b : b, where ~b is a mux of b selecting between constants.
module xor_bits_using_mux
   import xor_mux_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef XOR_MUX_PIPE_INVERT_EN
   input  logic             inv,
`endif
   output logic [WIDTH-1:0] y
);

   logic k0;
   logic k1;

`ifdef XOR_MUX_PIPE_INVERT_EN
   // Constant pair is swapped when inverting, turning every cell into XNOR.
   assign k0 = inv;
   assign k1 = mux2(inv, 1'b1, 1'b0);
`else
   assign k0 = 1'b0;
   assign k1 = 1'b1;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic nb;
      logic pb;
      assign nb   = mux2(b[i], k1, k0);
`ifdef XOR_MUX_PIPE_INVERT_EN
      assign pb   = mux2(b[i], k0, k1);
`else
      assign pb   = b[i];
`endif
      assign y[i] = mux2(a[i], pb, nb);
   end

endmodule

// File: rtl/xor_mux_pipe.sv
// Pipelined mux-built XOR with valid/ready flow control, parity and transfer count.
// Define XOR_MUX_PIPE_INVERT_EN to add the per-transfer "invert" (XNOR) input.
module xor_mux_pipe
   import xor_mux_pipe_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 2,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               up_valid,
   output logic               up_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
`ifdef XOR_MUX_PIPE_INVERT_EN
   input  logic               invert,
`endif
   output logic               down_valid,
   input  logic               down_ready,
   output logic [WIDTH-1:0]   y,
   output logic               parity,
   output logic [COUNT_W-1:0] count
);

   if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_depth_chk
      $error("xor_mux_pipe: DEPTH=%0d outside 1..%0d", DEPTH, MAX_DEPTH);
   end

   stage_t           stg  [DEPTH];
   logic [WIDTH-1:0] data [DEPTH];
   logic [DEPTH:0]   rdy;
   logic [WIDTH-1:0] res;
   logic             inv_in;
   logic             unused_inv;

`ifdef XOR_MUX_PIPE_INVERT_EN
   assign inv_in = invert;
   xor_bits_using_mux #(.WIDTH(WIDTH)) u_xor (.a(a), .b(b), .inv(invert), .y(res));
`else
   assign inv_in = 1'b0;
   xor_bits_using_mux #(.WIDTH(WIDTH)) u_xor (.a(a), .b(b), .y(res));
`endif

   // rdy[k] is the load enable of stage k; rdy[DEPTH] is the consumer.
   always_comb begin
      rdy[DEPTH] = down_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         rdy[k] = !stg[k].valid || rdy[k+1];
      end
   end

   assign up_ready = rdy[0];

   // Data only moves with a valid token, so X on idle inputs never reaches y.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            stg[k]  <= '0;
            data[k] <= '0;
         end
      end else begin
         if (rdy[0]) begin
            stg[0].valid <= up_valid;
            if (up_valid) begin
               data[0]       <= res;
               stg[0].parity <= ^res;
               stg[0].inv    <= inv_in;
            end
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) begin
               stg[k].valid <= stg[k-1].valid;
               if (stg[k-1].valid) begin
                  data[k]       <= data[k-1];
                  stg[k].parity <= stg[k-1].parity;
                  stg[k].inv    <= stg[k-1].inv;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (down_valid && down_ready) begin
         count <= count + COUNT_W'(1);
      end
   end

   assign down_valid = stg[DEPTH-1].valid;
   assign y          = data[DEPTH-1];
   assign parity     = stg[DEPTH-1].parity;
   assign unused_inv = stg[DEPTH-1].inv;

endmodule

// File: tb/tb_xor_mux_pipe.sv
// Directed bench for xor_mux_pipe (WIDTH=8, DEPTH=2) plus a COUNT_W=4 copy for wrap.
// Covers XOR_MUX_PIPE_INVERT_EN when that macro is defined.
module tb_xor_mux_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       up_valid;
   logic       down_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       invert;

   logic       up_ready,   up_ready_w;
   logic       down_valid, down_valid_w;
   logic [7:0] y,          y_w;
   logic       parity,     parity_w;
   logic [7:0] count;
   logic [3:0] count_w;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   xor_mux_pipe #(.WIDTH(8), .DEPTH(2), .COUNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready),
      .a(a), .b(b),
`ifdef XOR_MUX_PIPE_INVERT_EN
      .invert(invert),
`endif
      .down_valid(down_valid), .down_ready(down_ready),
      .y(y), .parity(parity), .count(count)
   );

   xor_mux_pipe #(.WIDTH(8), .DEPTH(2), .COUNT_W(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready_w),
      .a(a), .b(b),
`ifdef XOR_MUX_PIPE_INVERT_EN
      .invert(invert),
`endif
      .down_valid(down_valid_w), .down_ready(down_ready),
      .y(y_w), .parity(parity_w), .count(count_w)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      up_valid   = 1'b0;
      down_ready = 1'b0;
      a          = 8'h00;
      b          = 8'h00;
      invert     = 1'b0;
      rst_n      = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      up_valid   = 1'b0;
      down_ready = 1'b0;
      a          = 8'h00;
      b          = 8'h00;
      invert     = 1'b0;
      rst_n      = 1'b0;
      #12;
      n_cmp++;
      if ({down_valid, y, parity, count} !== 18'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: dv=%b y=%h par=%b cnt=%h, want all 0",
                  down_valid, y, parity, count);
      end
      tick();
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (up_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_up_ready: got %b want 1", up_ready);
      end
   endtask

   task automatic test_single();
      apply_reset();
      a = 8'hA5; b = 8'h0F; up_valid = 1'b1; down_ready = 1'b1;
      tick();
      up_valid = 1'b0; a = 8'h00; b = 8'h00;
      n_cmp++;
      if (down_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL single_cycle1: down_valid=%b want 0", down_valid);
      end
      tick();
      n_cmp++;
      if ({down_valid, y, parity, count} !== {1'b1, 8'hAA, 1'b0, 8'h00}) begin
         n_bad++;
         $display("FAIL single_cycle2: dv=%b y=%h par=%b cnt=%h, want dv=1 y=aa par=0 cnt=0",
                  down_valid, y, parity, count);
      end
      tick();
      n_cmp++;
      if ({down_valid, count} !== {1'b0, 8'h01}) begin
         n_bad++;
         $display("FAIL single_count: dv=%b cnt=%h, want dv=0 cnt=01", down_valid, count);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] idx;
      logic [7:0] exp;
      int         item_bad;
      apply_reset();
      down_ready = 1'b1;
      item_bad   = 0;
      for (int cyc = 0; cyc < 258; cyc++) begin
         idx = 8'(cyc);
         if (cyc < 256) begin
            up_valid = 1'b1;
            a = {4'h0, idx[7:4]};
            b = {4'h0, idx[3:0]};
         end else begin
            up_valid = 1'b0;
            a = 8'h00;
            b = 8'h00;
         end
         tick();
         if (cyc >= 1 && cyc <= 256) begin
            idx = 8'(cyc - 1);
            exp = {4'h0, idx[7:4]} ^ {4'h0, idx[3:0]};
            n_cmp++;
            if (down_valid !== 1'b1 || up_ready !== 1'b1 || y !== exp || parity !== ^exp) begin
               n_bad++;
               item_bad++;
               if (item_bad <= 5)
                  $display("FAIL b2b_item%0d: dv=%b rdy=%b y=%h par=%b, want dv=1 rdy=1 y=%h par=%b",
                           cyc - 1, down_valid, up_ready, y, parity, exp, ^exp);
            end
         end
      end
      n_cmp++;
      if ({down_valid, count, count_w} !== 13'h0) begin
         n_bad++;
         $display("FAIL b2b_end: dv=%b cnt=%h cnt_w=%h, want dv=0 cnt=00 cnt_w=0",
                  down_valid, count, count_w);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] ia  [4] = '{8'h3C, 8'hFF, 8'h80, 8'h12};
      logic [7:0] ib  [4] = '{8'h0F, 8'h01, 8'h80, 8'h34};
      logic [7:0] exp [4] = '{8'h33, 8'hFE, 8'h00, 8'h26};
      int sent;
      int got;
      apply_reset();
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         down_ready = (cyc >= 5);
         up_valid   = (sent < 4);
         a = (sent < 4) ? ia[sent] : 8'h00;
         b = (sent < 4) ? ib[sent] : 8'h00;
         #1;
         if (cyc >= 2 && cyc <= 4) begin
            n_cmp++;
            if (up_ready !== 1'b0 || sent != 2 || down_valid !== 1'b1 || y !== exp[0]) begin
               n_bad++;
               $display("FAIL bp_stall_c%0d: rdy=%b sent=%0d dv=%b y=%h, want rdy=0 sent=2 dv=1 y=%h",
                        cyc, up_ready, sent, down_valid, y, exp[0]);
            end
         end
         if (down_valid === 1'b1 && down_ready) begin
            n_cmp++;
            if (got >= 4) begin
               n_bad++;
               $display("FAIL bp_extra: unexpected item y=%h", y);
            end else if (y !== exp[got] || parity !== ^exp[got]) begin
               n_bad++;
               $display("FAIL bp_item%0d: y=%h par=%b, want y=%h par=%b",
                        got, y, parity, exp[got], ^exp[got]);
            end
            got++;
         end
         if (up_valid && up_ready === 1'b1) sent++;
         tick();
      end
      n_cmp++;
      if (got != 4 || sent != 4 || count !== 8'd4) begin
         n_bad++;
         $display("FAIL bp_total: got=%0d sent=%0d cnt=%0d, want 4 4 4", got, sent, count);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      down_ready = 1'b1;
      for (int cyc = 0; cyc < 19; cyc++) begin
         up_valid = (cyc < 17);
         a = 8'(cyc);
         b = 8'h00;
         tick();
         if (cyc == 16) begin
            n_cmp++;
            if (count_w !== 4'd15) begin
               n_bad++;
               $display("FAIL wrap_15: cnt_w=%0d want 15", count_w);
            end
         end
         if (cyc == 17) begin
            n_cmp++;
            if (count_w !== 4'd0) begin
               n_bad++;
               $display("FAIL wrap_16: cnt_w=%0d want 0", count_w);
            end
         end
         if (cyc == 18) begin
            n_cmp++;
            if (count_w !== 4'd1 || count !== 8'd17) begin
               n_bad++;
               $display("FAIL wrap_17: cnt_w=%0d cnt=%0d, want 1 17", count_w, count);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      down_ready = 1'b0;
      up_valid = 1'b1; a = 8'h11; b = 8'h22;
      tick();
      a = 8'h33; b = 8'h44;
      tick();
      up_valid = 1'b0;
      n_cmp++;
      if (down_valid !== 1'b1 || y !== 8'h33) begin
         n_bad++;
         $display("FAIL mid_prefill: dv=%b y=%h, want dv=1 y=33", down_valid, y);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({down_valid, y, parity, count} !== 18'h0 || up_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_reset: dv=%b y=%h par=%b cnt=%h rdy=%b, want 0 00 0 00 1",
                  down_valid, y, parity, count, up_ready);
      end
      tick();
      rst_n = 1'b1;
      a = 8'bx; b = 8'bx; down_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (down_valid !== 1'b0 || y !== 8'h00 || parity !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_after%0d: dv=%b y=%h par=%b, want 0 00 0", i, down_valid, y, parity);
         end
      end
      a = 8'h00; b = 8'h00;
   endtask

`ifdef XOR_MUX_PIPE_INVERT_EN
   task automatic test_invert();
      apply_reset();
      down_ready = 1'b1;
      up_valid = 1'b1; a = 8'hFF; b = 8'h00; invert = 1'b1;
      tick();
      a = 8'h0F; b = 8'h01; invert = 1'b0;
      tick();
      up_valid = 1'b0; invert = 1'b1;
      n_cmp++;
      if ({down_valid, y, parity} !== {1'b1, 8'h00, 1'b0}) begin
         n_bad++;
         $display("FAIL inv_item0: dv=%b y=%h par=%b, want 1 00 0", down_valid, y, parity);
      end
      tick();
      invert = 1'b0;
      n_cmp++;
      if ({down_valid, y, parity} !== {1'b1, 8'h0E, 1'b1}) begin
         n_bad++;
         $display("FAIL inv_item1: dv=%b y=%h par=%b, want 1 0e 1", down_valid, y, parity);
      end
   endtask
`endif

   initial begin
      rst_n      = 1'b0;
      up_valid   = 1'b0;
      down_ready = 1'b0;
      a          = 8'h00;
      b          = 8'h00;
      invert     = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_wrap();
      test_reset_mid();
`ifdef XOR_MUX_PIPE_INVERT_EN
      test_invert();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
